pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
- Carries an opaque payload of DATA_W bits between two pipeline stages using valid/ready handshakes.
- Supports stall, flush (branch interception) and an optional 2-entry skid buffer so that upstream ready is a registered signal.
- Instantiated once per stage boundary; the decoder/ALU bundles are concatenated into the payload bus by the surrounding stage logic.

---
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register carrying an opaque DATA_W payload.
// Optional 2-entry skid buffer gives a registered in_ready; flush discards all held entries.
module pipe_stage_skid #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned SKID      = 1,
  parameter int unsigned FLUSH_CLR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic acc;
  logic drn;
  logic clr;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready & ~stall;
  assign clr = rst | flush;

  generate
    if (SKID != 0) begin : g_skid
      state_t            state_q;
      logic              valid_q;
      logic              ready_q;
      logic [1:0]        occ_q;
      logic [DATA_W-1:0] head_q;
      logic [DATA_W-1:0] skid_q;

      // Outputs are updated alongside the state so in_ready comes straight from a flop.
      always_ff @(posedge clk) begin
        if (clr) begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          occ_q   <= 2'd0;
        end else begin
          case (state_q)
            EMPTY: if (acc) begin
              state_q <= ONE;
              valid_q <= 1'b1;
              occ_q   <= 2'd1;
            end
            ONE: if (acc && !drn) begin
              state_q <= TWO;
              ready_q <= 1'b0;
              occ_q   <= 2'd2;
            end else if (!acc && drn) begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
              occ_q   <= 2'd0;
            end
            TWO: if (drn) begin
              state_q <= ONE;
              ready_q <= 1'b1;
              occ_q   <= 2'd1;
            end
            default: begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              occ_q   <= 2'd0;
            end
          endcase
        end
      end

      // Payload has no reset at all unless FLUSH_CLR is set.
      always_ff @(posedge clk) begin
        if ((FLUSH_CLR != 0) && clr) begin
          head_q <= '0;
          skid_q <= '0;
        end else if (!clr) begin
          case (state_q)
            EMPTY: if (acc) head_q <= in_data;
            ONE: begin
              if (acc && drn) head_q <= in_data;
              else if (acc)   skid_q <= in_data;
            end
            TWO: if (drn) head_q <= skid_q;
            default: ;
          endcase
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = valid_q;
      assign out_data  = head_q;
      assign occupancy = occ_q;
    end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk) begin
        if (clr)      valid_q <= 1'b0;
        else if (acc) valid_q <= 1'b1;
        else if (drn) valid_q <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if ((FLUSH_CLR != 0) && clr) data_q <= '0;
        else if (!clr && acc)        data_q <= in_data;
      end

      assign in_ready  = ~valid_q | drn;
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table (SKID=1), streaming, SKID=0 sequence,
// and randomized backpressure against a queue reference model (DATA_W=7).
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default parameters (DATA_W=128, SKID=1, FLUSH_CLR=1)
  logic         a_flush = 0, a_stall = 0, a_in_valid = 0, a_out_ready = 0;
  logic [127:0] a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [1:0]   a_occ;

  pipe_stage_skid dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .stall(a_stall),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  // Instance B: single register
  logic       b_flush = 0, b_stall = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_occ;

  pipe_stage_skid #(.DATA_W(8), .SKID(0), .FLUSH_CLR(1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .stall(b_stall),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  // Instance C: narrow skid buffer for randomized traffic
  logic       c_flush = 0, c_stall = 0, c_in_valid = 0, c_out_ready = 0;
  logic [6:0] c_in_data = '0;
  logic       c_in_ready, c_out_valid;
  logic [6:0] c_out_data;
  logic [1:0] c_occ;

  pipe_stage_skid #(.DATA_W(7), .SKID(1), .FLUSH_CLR(1)) dut_c (
    .clk(clk), .rst(rst), .flush(c_flush), .stall(c_stall),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst, flush, stall, iv;
    logic [7:0] din;
    logic       ordy;
    logic       ov;
    logic [7:0] dout;
    logic       chk_d;
    logic [1:0] occ;
    logic       ir;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                              input logic [7:0] d, input logic o, input logic ev,
                              input logic [7:0] ed, input logic cd, input logic [1:0] eo,
                              input logic er);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.iv = v; t.din = d; t.ordy = o;
    t.ov = ev; t.dout = ed; t.chk_d = cd; t.occ = eo; t.ir = er;
    return t;
  endfunction

  vec_t tbl[$];

  logic [6:0] ref_q[$];
  logic       ref_v;
  int         ref_d, next_in, exp_out;
  logic       ir_before, take, give, b_acc, b_drn;

  initial begin
    // Expected state after the clock edge that consumes each row's inputs.
    //            rst flsh stl iv  din    ordy ov dout  chkd occ ir
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0, 1)); // reset
    tbl.push_back(mk(0, 0, 0, 1, 8'hA1, 0, 1, 8'hA1, 1, 2'd1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'hA2, 0, 1, 8'hA1, 1, 2'd2, 0)); // TWO
    tbl.push_back(mk(1, 0, 0, 1, 8'h33, 1, 0, 8'h00, 1, 2'd0, 1)); // reset mid-stream
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'h10, 1, 1, 8'h10, 1, 2'd1, 1)); // skid fill
    tbl.push_back(mk(0, 0, 1, 1, 8'h11, 1, 1, 8'h10, 1, 2'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h12, 1, 1, 8'h10, 1, 2'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h12, 0, 1, 8'h10, 1, 2'd2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h12, 1, 1, 8'h11, 1, 2'd1, 1)); // skid -> head
    tbl.push_back(mk(0, 0, 0, 1, 8'h12, 1, 1, 8'h12, 1, 2'd1, 1)); // ONE acc&drn
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'h20, 0, 1, 8'h20, 1, 2'd1, 1)); // flush collision
    tbl.push_back(mk(0, 0, 0, 1, 8'h21, 0, 1, 8'h20, 1, 2'd2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 1, 0, 8'h00, 1, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'h30, 0, 1, 8'h30, 1, 2'd1, 1)); // flush drops acc in ONE
    tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 0, 0, 8'h00, 1, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'h40, 0, 1, 8'h40, 1, 2'd1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 8'h41, 1, 0, 8'h00, 1, 2'd0, 1)); // rst with flush

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; a_flush = tbl[i].flush; a_stall = tbl[i].stall;
      a_in_valid = tbl[i].iv; a_in_data = {120'b0, tbl[i].din}; a_out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", i), 128'(a_out_valid), 128'(tbl[i].ov));
      chk($sformatf("tbl%0d_occupancy", i), 128'(a_occ), 128'(tbl[i].occ));
      chk($sformatf("tbl%0d_in_ready", i), 128'(a_in_ready), 128'(tbl[i].ir));
      if (tbl[i].chk_d)
        chk($sformatf("tbl%0d_out_data", i), a_out_data, {120'b0, tbl[i].dout});
    end
    @(negedge clk);
    rst = 0; a_flush = 0; a_stall = 0; a_in_valid = 0; a_out_ready = 0;

    // Full-rate streaming 1..16
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_data = 128'(k); a_out_ready = 1;
      @(posedge clk); #1;
      chk($sformatf("stream%0d_data", k), a_out_data, 128'(k));
      chk($sformatf("stream%0d_valid", k), 128'(a_out_valid), 128'd1);
      chk($sformatf("stream%0d_occ", k), 128'(a_occ), 128'd1);
      chk($sformatf("stream%0d_ready", k), 128'(a_in_ready), 128'd1);
    end
    @(negedge clk);
    a_in_valid = 0;
    @(posedge clk); #1;
    chk("stream_end_valid", 128'(a_out_valid), 128'd0);
    chk("stream_end_occ", 128'(a_occ), 128'd0);

    // SKID=0: stream 1..8 with out_ready toggling 1,0,1,0
    ref_v = 0; ref_d = 0; next_in = 1; exp_out = 1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      b_out_ready = (cyc % 2 == 0);
      b_in_valid  = (next_in <= 8);
      b_in_data   = 8'(next_in);
      #1;
      b_drn = ref_v && b_out_ready;
      b_acc = b_in_valid && (!ref_v || b_drn);
      chk("b_in_ready", 128'(b_in_ready), 128'(!ref_v || b_out_ready));
      chk("b_out_valid", 128'(b_out_valid), 128'(ref_v));
      chk("b_occupancy", 128'(b_occ), 128'({1'b0, ref_v}));
      if (ref_v) chk("b_out_data", 128'(b_out_data), 128'(ref_d));
      if (b_drn) begin
        chk("b_order", 128'(b_out_data), 128'(exp_out));
        exp_out++;
      end
      if (b_acc) begin
        ref_v = 1; ref_d = next_in; next_in++;
      end else if (b_drn) begin
        ref_v = 0;
      end
    end
    chk("b_drained_count", 128'(exp_out), 128'd9);
    @(negedge clk);
    b_in_valid = 0; b_out_ready = 0;

    // Randomized backpressure against a capacity-2 FIFO model
    ref_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ir_before   = c_in_ready;
      c_in_valid  = 1'($urandom_range(0, 1));
      c_in_data   = 7'($urandom);
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_stall     = ($urandom_range(0, 4) == 0);
      c_flush     = ($urandom_range(0, 63) == 0);
      #1;
      chk("c_ready_stable", 128'(c_in_ready), 128'(ir_before));
      chk("c_in_ready", 128'(c_in_ready), 128'(ref_q.size() < 2));
      chk("c_out_valid", 128'(c_out_valid), 128'(ref_q.size() != 0));
      chk("c_occupancy", 128'(c_occ), 128'(ref_q.size()));
      if (ref_q.size() != 0) chk("c_out_data", 128'(c_out_data), 128'(ref_q[0]));
      if (c_flush) begin
        ref_q.delete();
      end else begin
        take = c_in_valid && (ref_q.size() < 2);
        give = (ref_q.size() != 0) && c_out_ready && !c_stall;
        if (give) void'(ref_q.pop_front());
        if (take) ref_q.push_back(c_in_data);
      end
    end
    @(negedge clk);
    c_in_valid = 0; c_flush = 0; c_stall = 0; c_out_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
